spi_master_cfg: RTL

SPI_MASTER_CFG -- requirements
Module: spi_master_cfg

---
 rtl/spi_master_cfg.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/spi_master_cfg.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_cfg
// Purpose  : SPI master with run-time mode, bit order, divider and slave select
// Revision : 1.0 - initial release
// ============================================================================
module spi_master_cfg #(
    parameter int DATA_W = 8,
    parameter int NUM_SS = 4,
    parameter int DIV_W  = 8,
    localparam int SS_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [SS_W-1:0]   ss_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [DIV_W-1:0]  clk_div,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_SS-1:0] ss_n
);

    localparam int EC_W = $clog2(2 * DATA_W + 1);
    localparam logic [EC_W-1:0]   c_last_edge = EC_W'(2 * DATA_W);
    localparam logic [EC_W-1:0]   c_first_edge = EC_W'(1);
    localparam logic [NUM_SS-1:0] c_ss_one = NUM_SS'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_XFER  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t            r_state;
    logic [DIV_W-1:0]  r_div;
    logic [DIV_W-1:0]  r_div_cnt;
    logic [EC_W-1:0]   r_edge_cnt;
    logic [DATA_W-1:0] r_tx_sr;
    logic [DATA_W-1:0] r_rx_sr;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_cpha;
    logic              r_lsb;
    logic              r_sclk;
    logic              r_mosi;
    logic [NUM_SS-1:0] r_ss_n;
    logic              r_busy;
    logic              r_done;

    logic              w_tick;
    logic [EC_W-1:0]   w_edge_num;
    logic              w_lead;
    logic              w_sample;
    logic              w_shift;

    // Edge numbering starts at 1: odd edges are leading, even edges trailing.
    assign w_tick     = (r_div_cnt == r_div);
    assign w_edge_num = r_edge_cnt + 1'b1;
    assign w_lead     = w_edge_num[0];
    assign w_sample   = r_cpha ? !w_lead : w_lead;
    assign w_shift    = r_cpha ? (w_lead && (w_edge_num != c_first_edge))
                               : (!w_lead && (w_edge_num != c_last_edge));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_div      <= '0;
            r_div_cnt  <= '0;
            r_edge_cnt <= '0;
            r_tx_sr    <= '0;
            r_rx_sr    <= '0;
            r_rx_data  <= '0;
            r_cpha     <= 1'b0;
            r_lsb      <= 1'b0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_ss_n     <= '1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_sclk    <= cpol;
                    r_div_cnt <= '0;
                    if (start) begin
                        r_state    <= S_SETUP;
                        r_busy     <= 1'b1;
                        r_div      <= clk_div;
                        r_cpha     <= cpha;
                        r_lsb      <= lsb_first;
                        r_tx_sr    <= tx_data;
                        r_edge_cnt <= '0;
                        r_mosi     <= lsb_first ? tx_data[0] : tx_data[DATA_W-1];
                        // Out-of-range index shifts the one out: no line selected.
                        r_ss_n     <= ~(c_ss_one << ss_sel);
                    end
                end
                S_SETUP: begin
                    if (w_tick) begin
                        r_div_cnt <= '0;
                        r_state   <= S_XFER;
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end
                S_XFER: begin
                    if (w_tick) begin
                        r_div_cnt  <= '0;
                        r_sclk     <= ~r_sclk;
                        r_edge_cnt <= w_edge_num;
                        if (w_sample) begin
                            r_rx_sr <= r_lsb ? {miso, r_rx_sr[DATA_W-1:1]}
                                             : {r_rx_sr[DATA_W-2:0], miso};
                        end
                        if (w_shift) begin
                            if (r_lsb) begin
                                r_tx_sr <= r_tx_sr >> 1;
                                r_mosi  <= r_tx_sr[1];
                            end else begin
                                r_tx_sr <= r_tx_sr << 1;
                                r_mosi  <= r_tx_sr[DATA_W-2];
                            end
                        end
                        if (w_edge_num == c_last_edge) begin
                            r_state <= S_HOLD;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_tick) begin
                        r_div_cnt <= '0;
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_ss_n    <= '1;
                        r_rx_data <= r_rx_sr;
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rx_data = r_rx_data;
    assign busy    = r_busy;
    assign done    = r_done;
    assign sclk    = r_sclk;
    assign mosi    = r_mosi;
    assign ss_n    = r_ss_n;

endmodule
`default_nettype wire
